// File: rtl/gcd_pkg.sv
// Shared types and default sizing for the GCD client slice.
package gcd_pkg;

    localparam int unsigned GCD_WIDTH   = 4;
    localparam int unsigned GCD_TIMEOUT = 64;
    localparam int unsigned GCD_CNT_W   = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } gcd_state_e;

endpackage

// File: rtl/gcd_client_if.sv
// Operand/result handshake bundle between a requester and the GCD client.
interface gcd_client_if
    import gcd_pkg::*;
#(
    parameter int unsigned WIDTH = GCD_WIDTH
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_gcd;
    logic [WIDTH-1:0] res_a;
    logic [WIDTH-1:0] res_b;
    logic             res_err;

    // Requester side: offers operands, consumes results.
    modport master (
        output in_valid, in_a, in_b, res_ready,
        input  in_ready, res_valid, res_gcd, res_a, res_b, res_err
    );

    // Client side: accepts operands, presents results.
    modport slave (
        input  in_valid, in_a, in_b, res_ready,
        output in_ready, res_valid, res_gcd, res_a, res_b, res_err
    );

endinterface

// File: rtl/gcd_watchdog.sv
// Cycle counter that flags when an engine operation has run too long.
module gcd_watchdog
    import gcd_pkg::*;
#(
    parameter int unsigned TIMEOUT = GCD_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Last enabled cycle before the count would reach TIMEOUT.
    assign expired = enable && (cnt_q == CW'(TIMEOUT - 1));

    // Count enabled cycles from zero; hold once expired.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && !expired) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/gcd_client.sv
// Sequences one operand pair at a time through an external GCD engine,
// short-circuits b==0, and aborts engine runs that exceed TIMEOUT cycles.
module gcd_client
    import gcd_pkg::*;
#(
    parameter int unsigned WIDTH   = GCD_WIDTH,
    parameter int unsigned TIMEOUT = GCD_TIMEOUT
) (
    input  logic                 clk,
    input  logic                 rst,
    gcd_client_if.slave          bus,
    output logic                 gcd_start,
    output logic [WIDTH-1:0]     gcd_a,
    output logic [WIDTH-1:0]     gcd_b,
    output logic                 gcd_rst,
    input  logic [WIDTH-1:0]     gcd_out,
    input  logic                 gcd_done,
    input  logic                 gcd_busy,
    output logic [GCD_CNT_W-1:0] ops_cnt,
    output logic [GCD_CNT_W-1:0] err_cnt
);

    gcd_state_e state_q, state_d;

    logic [WIDTH-1:0]     res_gcd_q, res_gcd_d;
    logic [WIDTH-1:0]     res_a_q, res_a_d;
    logic [WIDTH-1:0]     res_b_q, res_b_d;
    logic                 res_err_q, res_err_d;
    logic [WIDTH-1:0]     gcd_a_q, gcd_a_d;
    logic [WIDTH-1:0]     gcd_b_q, gcd_b_d;
    logic                 tmo_q, tmo_d;
    logic [GCD_CNT_W-1:0] ops_q, ops_d;
    logic [GCD_CNT_W-1:0] err_q, err_d;

    logic start_c;
    logic wd_enable_c;
    logic wd_expired;

    // Watchdog runs only while an engine result is awaited.
    gcd_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (state_q != WAIT),
        .enable  (wd_enable_c),
        .expired (wd_expired)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath next values.
    always_comb begin
        state_d     = state_q;
        res_gcd_d   = res_gcd_q;
        res_a_d     = res_a_q;
        res_b_d     = res_b_q;
        res_err_d   = res_err_q;
        gcd_a_d     = gcd_a_q;
        gcd_b_d     = gcd_b_q;
        tmo_d       = 1'b0;
        ops_d       = ops_q;
        err_d       = err_q;
        start_c     = 1'b0;
        wd_enable_c = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    res_a_d = bus.in_a;
                    res_b_d = bus.in_b;
                    if (bus.in_b == '0) begin
                        // Engine would never finish for b==0; answer is a.
                        res_gcd_d = bus.in_a;
                        res_err_d = 1'b0;
                        state_d   = HOLD;
                    end else begin
                        gcd_a_d = bus.in_a;
                        gcd_b_d = bus.in_b;
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (!gcd_busy) begin
                    start_c = 1'b1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                wd_enable_c = 1'b1;
                if (gcd_done) begin
                    res_gcd_d = gcd_out;
                    res_err_d = 1'b0;
                    state_d   = HOLD;
                end else if (wd_expired) begin
                    res_gcd_d = '0;
                    res_err_d = 1'b1;
                    tmo_d     = 1'b1;
                    state_d   = HOLD;
                end
            end
            HOLD: begin
                if (bus.res_ready) begin
                    state_d = IDLE;
                    if (res_err_q) begin
                        err_d = err_q + GCD_CNT_W'(1);
                    end else begin
                        ops_d = ops_q + GCD_CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_gcd_q <= '0;
            res_a_q   <= '0;
            res_b_q   <= '0;
            res_err_q <= 1'b0;
            gcd_a_q   <= '0;
            gcd_b_q   <= '0;
            tmo_q     <= 1'b0;
            ops_q     <= '0;
            err_q     <= '0;
        end else begin
            res_gcd_q <= res_gcd_d;
            res_a_q   <= res_a_d;
            res_b_q   <= res_b_d;
            res_err_q <= res_err_d;
            gcd_a_q   <= gcd_a_d;
            gcd_b_q   <= gcd_b_d;
            tmo_q     <= tmo_d;
            ops_q     <= ops_d;
            err_q     <= err_d;
        end
    end

    // Handshake flags are masked during reset so nothing is offered or taken.
    assign bus.in_ready  = (state_q == IDLE) && !rst;
    assign bus.res_valid = (state_q == HOLD) && !rst;
    assign bus.res_gcd   = res_gcd_q;
    assign bus.res_a     = res_a_q;
    assign bus.res_b     = res_b_q;
    assign bus.res_err   = res_err_q;

    assign gcd_start = start_c && !rst;
    assign gcd_a     = gcd_a_q;
    assign gcd_b     = gcd_b_q;
    assign gcd_rst   = rst || tmo_q;
    assign ops_cnt   = ops_q;
    assign err_cnt   = err_q;

endmodule

// File: tb/tb_gcd_client.sv
// Directed bench for gcd_client with a behavioural subtractive GCD engine.
module tb_gcd_client;
    import gcd_pkg::*;

    localparam int unsigned W  = GCD_WIDTH;
    localparam int unsigned TO = GCD_TIMEOUT;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    gcd_client_if #(.WIDTH(W)) bus ();

    logic                 gcd_start;
    logic                 gcd_rst;
    logic [W-1:0]         gcd_a;
    logic [W-1:0]         gcd_b;
    logic [W-1:0]         gcd_out;
    logic                 gcd_done;
    logic                 gcd_busy;
    logic [GCD_CNT_W-1:0] ops_cnt;
    logic [GCD_CNT_W-1:0] err_cnt;

    gcd_client #(
        .WIDTH   (W),
        .TIMEOUT (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .gcd_start (gcd_start),
        .gcd_a     (gcd_a),
        .gcd_b     (gcd_b),
        .gcd_rst   (gcd_rst),
        .gcd_out   (gcd_out),
        .gcd_done  (gcd_done),
        .gcd_busy  (gcd_busy),
        .ops_cnt   (ops_cnt),
        .err_cnt   (err_cnt)
    );

    // Engine model: subtractive Euclid, or a stub that never finishes.
    logic         stub     = 1'b0;
    logic         inj_done = 1'b0;
    logic [W-1:0] eng_a    = '0;
    logic [W-1:0] eng_b    = '0;
    logic [W-1:0] eng_out  = '0;
    logic         eng_busy = 1'b0;
    logic         eng_done = 1'b0;

    logic         s_start = 1'b0;
    logic         s_rst   = 1'b1;
    logic         s_inj   = 1'b0;
    logic [W-1:0] s_a     = '0;
    logic [W-1:0] s_b     = '0;
    int           n_start = 0;
    int           n_tmo   = 0;

    assign gcd_out  = eng_out;
    assign gcd_busy = eng_busy;
    assign gcd_done = eng_done | inj_done;

    // Mid-cycle snapshot of client outputs feeding the engine and pulse counters.
    always @(negedge clk) begin
        s_start = gcd_start;
        s_rst   = gcd_rst;
        s_inj   = inj_done;
        s_a     = gcd_a;
        s_b     = gcd_b;
        if (gcd_start) n_start++;
        if (gcd_rst && !rst) n_tmo++;
    end

    always @(posedge clk) begin
        eng_done <= 1'b0;
        if (s_rst) begin
            eng_busy <= 1'b0;
            eng_a    <= '0;
            eng_b    <= '0;
            eng_out  <= '0;
        end else if (s_start && !eng_busy) begin
            eng_a    <= s_a;
            eng_b    <= s_b;
            eng_busy <= 1'b1;
        end else if (s_inj) begin
            eng_busy <= 1'b0;
        end else if (eng_busy && !stub) begin
            if (eng_b == '0) begin
                eng_out  <= eng_a;
                eng_done <= 1'b1;
                eng_busy <= 1'b0;
            end else if (eng_a < eng_b) begin
                eng_a <= eng_b;
                eng_b <= eng_a;
            end else begin
                eng_a <= eng_a - eng_b;
            end
        end
    end

    int n_vec   = 0;
    int n_bad   = 0;
    int exp_ops = 0;
    int exp_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // Offer one pair in IDLE; returns at the sample point one cycle after acceptance.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
        tick();
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        smp();
        chk("in_ready_at_accept", 32'(bus.in_ready), 1);
        tick();
        bus.in_valid = 1'b0;
        smp();
    endtask

    task automatic wait_res();
        int cyc;
        cyc = 0;
        while (!bus.res_valid && cyc < 200) begin
            tick();
            smp();
            cyc++;
        end
        chk("res_valid_within_bound", 32'(bus.res_valid), 1);
    endtask

    task automatic take();
        tick();
        bus.res_ready = 1'b1;
        smp();
        tick();
        bus.res_ready = 1'b0;
        smp();
        chk("in_ready_after_take", 32'(bus.in_ready), 1);
    endtask

    task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input int g);
        send(a, b);
        wait_res();
        chk("res_gcd", 32'(bus.res_gcd), 32'(g));
        chk("res_a_echo", 32'(bus.res_a), 32'(a));
        chk("res_b_echo", 32'(bus.res_b), 32'(b));
        chk("res_err_clear", 32'(bus.res_err), 0);
        take();
        exp_ops++;
        chk("ops_cnt", 32'(ops_cnt), 32'(exp_ops));
    endtask

    task automatic bypass_op(input logic [W-1:0] a, input int g);
        int s0;
        s0 = n_start;
        send(a, '0);
        chk("bypass_valid_next_cycle", 32'(bus.res_valid), 1);
        chk("bypass_gcd", 32'(bus.res_gcd), 32'(g));
        chk("bypass_err", 32'(bus.res_err), 0);
        take();
        exp_ops++;
        chk("bypass_ops_cnt", 32'(ops_cnt), 32'(exp_ops));
        chk("bypass_no_start", 32'(n_start - s0), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_time_limit: observed no finish expected finish");
        $fatal(1);
    end

    initial begin
        int s0;
        int r0;
        int cyc;
        logic seen;

        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.res_ready = 1'b0;

        // Reset cycle.
        smp();
        chk("rst_in_ready", 32'(bus.in_ready), 0);
        chk("rst_res_valid", 32'(bus.res_valid), 0);
        chk("rst_gcd_start", 32'(gcd_start), 0);
        chk("rst_gcd_rst", 32'(gcd_rst), 1);
        chk("rst_res_gcd", 32'(bus.res_gcd), 0);
        chk("rst_gcd_a", 32'(gcd_a), 0);
        chk("rst_ops", 32'(ops_cnt), 0);
        chk("rst_err", 32'(err_cnt), 0);
        tick();
        rst = 1'b0;
        smp();
        chk("post_rst_in_ready", 32'(bus.in_ready), 1);
        chk("post_rst_gcd_rst", 32'(gcd_rst), 0);

        // Stray done in IDLE is ignored.
        tick();
        inj_done = 1'b1;
        smp();
        tick();
        inj_done = 1'b0;
        smp();
        chk("idle_done_no_valid", 32'(bus.res_valid), 0);
        chk("idle_done_in_ready", 32'(bus.in_ready), 1);
        chk("idle_done_ops", 32'(ops_cnt), 0);

        // Real engine, single start pulse.
        s0 = n_start;
        op(4'd12, 4'd8, 4);
        chk("start_pulses_12_8", 32'(n_start - s0), 1);

        bypass_op(4'd9, 9);
        bypass_op(4'd0, 0);
        op(4'd0, 4'd6, 6);
        op(4'd7, 4'd7, 7);
        op(4'd15, 4'd1, 1);

        // Stall in HOLD with a competing offer and a stray done.
        send(4'd10, 4'd4);
        wait_res();
        for (int i = 0; i < 10; i++) begin
            tick();
            bus.in_valid = 1'b1;
            bus.in_a     = 4'd3;
            bus.in_b     = 4'd3;
            inj_done     = (i == 4);
            smp();
            chk("hold_valid", 32'(bus.res_valid), 1);
            chk("hold_gcd", 32'(bus.res_gcd), 2);
            chk("hold_res_a", 32'(bus.res_a), 10);
            chk("hold_in_ready", 32'(bus.in_ready), 0);
        end
        tick();
        bus.in_valid = 1'b0;
        inj_done     = 1'b0;
        smp();
        take();
        exp_ops++;
        chk("hold_ops_cnt", 32'(ops_cnt), 32'(exp_ops));
        tick();
        smp();
        chk("hold_second_not_taken", 32'(bus.in_ready), 1);
        chk("hold_res_a_kept", 32'(bus.res_a), 10);

        // Timeout with a stub engine.
        stub = 1'b1;
        r0 = n_tmo;
        send(4'd5, 4'd3);
        chk("tmo_start", 32'(gcd_start), 1);
        cyc = 0;
        while (!bus.res_valid && cyc < 200) begin
            tick();
            smp();
            cyc++;
            if (cyc == 32) begin
                chk("wait_gcd_a", 32'(gcd_a), 5);
                chk("wait_gcd_b", 32'(gcd_b), 3);
            end
        end
        chk("tmo_cycles_to_hold", 32'(cyc), 65);
        chk("tmo_err", 32'(bus.res_err), 1);
        chk("tmo_gcd_zero", 32'(bus.res_gcd), 0);
        chk("tmo_res_a", 32'(bus.res_a), 5);
        chk("tmo_gcd_rst_high", 32'(gcd_rst), 1);
        tick();
        smp();
        chk("tmo_gcd_rst_low", 32'(gcd_rst), 0);
        chk("tmo_still_valid", 32'(bus.res_valid), 1);
        chk("tmo_rst_pulses", 32'(n_tmo - r0), 1);
        take();
        exp_err++;
        chk("tmo_err_cnt", 32'(err_cnt), 32'(exp_err));
        chk("tmo_ops_unchanged", 32'(ops_cnt), 32'(exp_ops));
        stub = 1'b0;
        op(4'd6, 4'd4, 2);

        // Done and timeout on the same cycle: done wins (engine output still 2).
        stub = 1'b1;
        send(4'd13, 4'd5);
        cyc = 0;
        while (!bus.res_valid && cyc < 200) begin
            tick();
            cyc++;
            inj_done = (cyc == 64);
            smp();
        end
        tick();
        inj_done = 1'b0;
        smp();
        chk("tie_cycles", 32'(cyc), 65);
        chk("tie_err", 32'(bus.res_err), 0);
        chk("tie_gcd", 32'(bus.res_gcd), 2);
        chk("tie_no_gcd_rst", 32'(gcd_rst), 0);
        take();
        exp_ops++;
        chk("tie_ops_cnt", 32'(ops_cnt), 32'(exp_ops));

        // Reset in the middle of WAIT.
        send(4'd9, 4'd6);
        for (int i = 0; i < 5; i++) begin
            tick();
            smp();
        end
        tick();
        rst = 1'b1;
        smp();
        chk("midrst_res_valid", 32'(bus.res_valid), 0);
        chk("midrst_in_ready", 32'(bus.in_ready), 0);
        chk("midrst_gcd_rst", 32'(gcd_rst), 1);
        tick();
        rst = 1'b0;
        stub = 1'b0;
        smp();
        exp_ops = 0;
        exp_err = 0;
        chk("midrst_after_in_ready", 32'(bus.in_ready), 1);
        chk("midrst_ops", 32'(ops_cnt), 0);
        chk("midrst_err", 32'(err_cnt), 0);
        chk("midrst_gcd_a", 32'(gcd_a), 0);
        chk("midrst_res_gcd", 32'(bus.res_gcd), 0);
        seen = 1'b0;
        for (int i = 0; i < 80; i++) begin
            tick();
            smp();
            if (bus.res_valid) seen = 1'b1;
        end
        chk("midrst_no_result", 32'(seen), 0);
        op(4'd8, 4'd12, 4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/gcd_client.md
GCD_CLIENT -- requirements
Module: gcd_client

Interface
REQ-001 Parameter WIDTH, default 4: operand and result width.
REQ-002 Parameter TIMEOUT, default 64: maximum WAIT cycles before abort.
REQ-003 Clock clk, 1 bit; reset rst, synchronous, active-high.
REQ-004 in_valid  input  1  operand pair offered.
REQ-005 in_ready  output  1  client can accept a pair.
REQ-006 in_a, in_b  input  WIDTH  operands.
REQ-007 res_valid  output  1  result held.
REQ-008 res_ready  input  1  consumer accepts the result.
REQ-009 res_gcd  output  WIDTH  result value.
REQ-010 res_a, res_b  output  WIDTH  echoed operands.
REQ-011 res_err  output  1  result aborted by timeout.
REQ-012 gcd_start  output  1  start pulse to the engine.
REQ-013 gcd_a, gcd_b  output  WIDTH  engine operands.
REQ-014 gcd_rst  output  1  engine reset request.
REQ-015 gcd_out  input  WIDTH  engine result.
REQ-016 gcd_done, gcd_busy  input  1  engine status.
REQ-017 ops_cnt, err_cnt  output  8  completed and aborted counts; both wrap.

Function
REQ-018 The FSM SHALL have four states: IDLE, ISSUE, WAIT and HOLD.
REQ-019 IDLE: in_ready=1; on in_valid, latch in_a/in_b; go to HOLD if in_b==0, else go to ISSUE.
REQ-020 b==0 bypass: res_gcd=in_a (0 when both are 0), res_err=0, engine untouched; res_valid rises the cycle after acceptance, because the engine never terminates for a!=0, b==0.
REQ-021 ISSUE: gcd_start=1 only while gcd_busy==0; go to WAIT on the cycle start is asserted; gcd_start is exactly one cycle per operation.
REQ-022 gcd_a/gcd_b SHALL hold the latched operands from ISSUE through WAIT.
REQ-023 WAIT: the watchdog counts from 0, one per cycle; on gcd_done, capture gcd_out into res_gcd, res_err=0, go to HOLD.
REQ-024 If the watchdog reaches TIMEOUT without gcd_done: res_err=1, res_gcd=0, gcd_rst=1 for exactly that next cycle, go to HOLD.
REQ-025 If gcd_done and the timeout occur in the same cycle, done SHALL win.
REQ-026 gcd_done seen outside WAIT SHALL be ignored.
REQ-027 HOLD: res_valid=1; res_gcd/res_a/res_b/res_err stable; in_ready=0; on res_ready go to IDLE.
REQ-028 ops_cnt SHALL increment on every accepted non-error result; err_cnt on every accepted error result.
REQ-029 Throughput: at most one operation in flight; in_ready=1 only in IDLE.
REQ-030 gcd_rst SHALL equal rst OR the timeout pulse; the system SHALL drive the engine reset from gcd_rst.

Reset
REQ-031 On rst (sampled at clk): state=IDLE, in_ready=0 during the reset cycle, and these outputs 0: res_valid, res_err, res_gcd, res_a, res_b, gcd_start, gcd_a, gcd_b, ops_cnt, err_cnt, watchdog.
REQ-032 rst mid-WAIT or mid-HOLD SHALL drop the pending result silently; gcd_rst is high for the reset so the engine is also cleared.

Structure
REQ-033 Package gcd_pkg SHALL hold the state enum (IDLE, ISSUE, WAIT, HOLD) and the default WIDTH/TIMEOUT constants.
REQ-034 Sub-module gcd_watchdog (clear, enable, expired; TIMEOUT parameter) SHALL implement the counter; everything else lives in gcd_client.

Verification
REQ-035 Stimulus (12,8) with the real engine -> res_gcd=4, res_err=0, ops_cnt=1, exactly one gcd_start pulse.
REQ-036 Stimulus (9,0) -> res_gcd=9, res_valid one cycle after acceptance, no gcd_start; (0,0) -> 0.
REQ-037 Stimulus (0,6) -> 6; (7,7) -> 7; (15,1) -> 1.
REQ-038 res_ready held low 10 cycles in HOLD -> outputs stable, in_ready=0, a second in_valid is not accepted.
REQ-039 Stub engine that never asserts done, TIMEOUT=64 -> res_err=1 after 64 WAIT cycles, one-cycle gcd_rst pulse, err_cnt=1; the next pair then completes normally.
REQ-040 rst asserted mid-WAIT -> res_valid=0 and in_ready=0 during the reset cycle, in_ready=1 the cycle after rst deasserts, no result emitted, counters 0.
